serial_adder_driver: RTL and testbench



---
 rtl/serial_adder_driver.sv | 112 +++++++++++
 tb/tb_serial_adder_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_driver.sv
// serial_adder_driver
//
// This block is the parallel-to-serial front end for serial_adder_with_vld.
// It accepts an operand pair over a valid/ready handshake. It then shifts
// both operands out LSB-first on the vld/a/b/last serial protocol. The
// adder's per-beat sum bit is collected back into a parallel result.
//
// State table:
//   state     | meaning
//   ST_IDLE   | no transfer in progress, ready for an operand pair
//   ST_SEND   | shifting an operand pair out, one bit per unpaused cycle
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (also resets the adder)
//   in_valid   operand pair valid
//   in_ready   operand pair can be accepted this cycle
//   in_a/in_b  WIDTH-bit operands, sampled on accept
//   pause      stall request, forces a bubble this cycle
//   ser_vld    serial beat valid  -> adder vld
//   ser_a      current bit of A   -> adder a
//   ser_b      current bit of B   -> adder b
//   ser_last   final beat         -> adder last
//   ser_sum    adder sum bit, combinational in the beat cycle
//   res_valid  one-cycle pulse when res_sum updates
//   res_sum    last completed WIDTH-bit result
//   busy       transfer in progress
module serial_adder_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             pause,
    output logic             ser_vld,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last,
    input  logic             ser_sum,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             accept;

    assign busy     = (state == ST_SEND);
    assign ser_vld  = busy && !pause;
    assign ser_a    = ser_vld && sh_a[0];
    assign ser_b    = ser_vld && sh_b[0];
    assign ser_last = ser_vld && (cnt == CW'(WIDTH - 1));

    // A new pair can be taken on the last beat, which keeps ser_vld
    // continuous when the producer streams back to back.
    assign in_ready = !rst && (!busy || ser_last);
    assign accept   = in_valid && in_ready;

    // The first beat's sum bit walks down to bit 0 after WIDTH shifts.
    // This form also covers WIDTH=1 without a reversed slice.
    always_comb begin
        acc_next            = acc >> 1;
        acc_next[WIDTH-1]   = ser_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            acc       <= '0;
            res_sum   <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (ser_vld) begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
                acc  <= acc_next;
                cnt  <= cnt + CW'(1);
                if (ser_last) begin
                    res_sum   <= acc_next;
                    res_valid <= 1'b1;
                    state     <= ST_IDLE;
                    cnt       <= '0;
                end
            end
            // A load overrides the end-of-transfer return to idle.
            if (accept) begin
                sh_a  <= in_a;
                sh_b  <= in_b;
                cnt   <= '0;
                state <= ST_SEND;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_driver.sv
module tb_serial_adder_driver;

    logic       clk = 1'b0;
    logic       rst;

    // WIDTH=8 instance
    logic       in_valid, in_ready, pause;
    logic [7:0] in_a, in_b;
    logic       ser_vld, ser_a, ser_b, ser_last, ser_sum;
    logic       res_valid, busy;
    logic [7:0] res_sum;
    logic       carry;

    // WIDTH=1 instance
    logic       in_valid1, in_ready1, pause1;
    logic [0:0] in_a1, in_b1;
    logic       ser_vld1, ser_a1, ser_b1, ser_last1, ser_sum1;
    logic       res_valid1, busy1;
    logic [0:0] res_sum1;
    logic       carry1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_driver #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .pause(pause), .ser_vld(ser_vld),
        .ser_a(ser_a), .ser_b(ser_b), .ser_last(ser_last), .ser_sum(ser_sum),
        .res_valid(res_valid), .res_sum(res_sum), .busy(busy)
    );

    serial_adder_driver #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .pause(pause1), .ser_vld(ser_vld1),
        .ser_a(ser_a1), .ser_b(ser_b1), .ser_last(ser_last1), .ser_sum(ser_sum1),
        .res_valid(res_valid1), .res_sum(res_sum1), .busy(busy1)
    );

    // Behavioural serial adder: full adder whose carry is cleared on last/rst.
    assign ser_sum  = ser_a ^ ser_b ^ carry;
    assign ser_sum1 = ser_a1 ^ ser_b1 ^ carry1;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry  <= 1'b0;
            carry1 <= 1'b0;
        end else begin
            if (ser_vld)
                carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (carry & (ser_a ^ ser_b)));
            if (ser_vld1)
                carry1 <= ser_last1 ? 1'b0 : ((ser_a1 & ser_b1) | (carry1 & (ser_a1 ^ ser_b1)));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] pmask;   // bit k: insert one bubble before beat k
        logic [7:0] sum;
        int         lat;     // cycles from accept edge to res_valid
    } vec_t;

    vec_t vecs[8];

    // Accept one pair from idle, then run it to completion with the given
    // pause pattern and check beats, timing and the result.
    task automatic run_op(input vec_t v);
        int         beats = 0;
        int         last_cyc = -1;
        int         rv_cyc = -1;
        int         pulses = 0;
        logic [7:0] rv_val = '0;
        logic [7:0] sa = '0;
        logic [7:0] sb = '0;
        bit         pflag = 0;
        bit         bubble_ok = 1;
        bit         last_ok = 1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = v.a; in_b = v.b; pause = 1'b0;
        @(negedge clk);
        chk("ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= v.lat + 2; cyc++) begin
            pause = (beats < 8) && v.pmask[beats] && !pflag;
            @(negedge clk);
            if (ser_vld) begin
                sa[beats] = ser_a;
                sb[beats] = ser_b;
                if (ser_last) last_cyc = cyc;
                if (ser_last !== (beats == 7)) last_ok = 0;
                beats++;
                pflag = 0;
            end else if (beats < 8) begin
                if (ser_a || ser_b || ser_last || !busy) bubble_ok = 0;
                pflag = 1;
            end
            if (res_valid) begin
                pulses++;
                rv_cyc = cyc;
                rv_val = res_sum;
            end
            @(posedge clk); #1;
        end
        pause = 1'b0;
        chk("ser_a_seq", sa, v.a);
        chk("ser_b_seq", sb, v.b);
        chk("bubble_zero", bubble_ok, 1);
        chk("last_only_final", last_ok, 1);
        chk("last_cycle", last_cyc, v.lat - 1);
        chk("res_valid_cycle", rv_cyc, v.lat);
        chk("res_valid_pulses", pulses, 1);
        chk("res_sum", rv_val, v.sum);
    endtask

    initial begin
        int         nacc, run, maxrun, np;
        bit         acc_now, last_at_acc2;
        int         rcyc[2];
        logic [7:0] rval[2];
        bit         rv_seen;

        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; pause = 0;
        in_valid1 = 0; in_a1 = 0; in_b1 = 0; pause1 = 0;

        vecs[0] = '{8'h35, 8'h4A, 8'h00, 8'h7F, 9};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 8'h00, 9};
        vecs[2] = '{8'h96, 8'h2D, 8'h4C, 8'hC3, 12};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 9};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 8'h00, 9};
        vecs[5] = '{8'h7F, 8'h01, 8'h00, 8'h80, 9};
        vecs[6] = '{8'h12, 8'h34, 8'h01, 8'h46, 10};
        vecs[7] = '{8'hAB, 8'hCD, 8'h80, 8'h78, 10};

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_in_reset", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ser_vld", ser_vld, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_ready_after", in_ready, 1);

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-to-back: 0x01+0x02 then 0x10+0x20 with in_valid held
        @(posedge clk); #1;
        in_valid = 1; in_a = 8'h01; in_b = 8'h02;
        nacc = 0; run = 0; maxrun = 0; np = 0; last_at_acc2 = 0;
        rcyc[0] = 0; rcyc[1] = 0; rval[0] = 0; rval[1] = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            acc_now = in_valid && in_ready;
            if (ser_vld) run++; else run = 0;
            if (run > maxrun) maxrun = run;
            if (acc_now && nacc == 1) last_at_acc2 = ser_last;
            if (res_valid) begin
                if (np < 2) begin rcyc[np] = cyc; rval[np] = res_sum; end
                np++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                nacc++;
                if (nacc == 1) begin in_a = 8'h10; in_b = 8'h20; end
                else in_valid = 0;
            end
        end
        in_valid = 0;
        chk("b2b_accepts", nacc, 2);
        chk("b2b_accept_on_last", last_at_acc2, 1);
        chk("b2b_vld_run", maxrun, 16);
        chk("b2b_pulses", np, 2);
        chk("b2b_res0", rval[0], 8'h03);
        chk("b2b_res1", rval[1], 8'h30);
        chk("b2b_spacing", rcyc[1] - rcyc[0], 8);

        // Reset during beat 4 of 0xAA+0x55
        @(posedge clk); #1;
        in_valid = 1; in_a = 8'hAA; in_b = 8'h55;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("mid_beat4_vld", ser_vld, 1);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", ser_vld, 0);
        chk("mid_rst_busy", busy, 0);
        rv_seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (res_valid) rv_seen = 1;
            @(negedge clk);
        end
        chk("mid_rst_no_result", rv_seen, 0);
        chk("mid_rst_res_sum", res_sum, 0);
        run_op('{8'h0F, 8'h01, 8'h00, 8'h10, 9});

        // WIDTH=1 instance, 1+1
        @(posedge clk); #1;
        in_valid1 = 1; in_a1 = 1'b1; in_b1 = 1'b1;
        @(negedge clk);
        chk("w1_ready", in_ready1, 1);
        @(posedge clk); #1;
        in_valid1 = 0;
        @(negedge clk);
        chk("w1_vld", ser_vld1, 1);
        chk("w1_last", ser_last1, 1);
        chk("w1_busy", busy1, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w1_vld_after", ser_vld1, 0);
        chk("w1_res_valid", res_valid1, 1);
        chk("w1_res_sum", res_sum1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
